// File: rtl/gfx_pkg.sv
// Shared graphics definitions: animation FSM encoding, scroll width, brightness range.
package gfx_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HOLD     = 2'd1,
        ST_FADE_OUT = 2'd2,
        ST_FADE_IN  = 2'd3
    } anim_state_t;

    localparam int          SCROLL_W   = 10;
    localparam int          SCENE_W    = 3;
    localparam logic [1:0]  BRIGHT_MAX = 2'd3;

endpackage

// File: rtl/vsync_edge_detect.sv
// Brings an asynchronous frame-rate strobe into clk and emits a registered
// one-cycle pulse on each rising edge. Shared by frame-rate blocks.
module vsync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   pulse_q;

    // Synchronizer chain, history flop and registered rising-edge compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/anim_sequencer.sv
// Frame-rate animation sequencer: scrolls two parallax layers, counts scene
// frames, supports pause, and optionally fades between scenes.
// Optional feature: define ANIM_FADE_EN to enable the FADE_OUT/FADE_IN states;
// without it a scene end simply advances scene_idx and brightness stays full.
module anim_sequencer
    import gfx_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int SCENE_FRAMES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                v_sync,
    input  logic                pause_req,
    input  logic [1:0]          speed,
    output logic                frame_tick,
    output logic [SCROLL_W-1:0] scroll_fg,
    output logic [SCROLL_W-1:0] scroll_bg,
    output logic [SCENE_W-1:0]  scene_idx,
    output logic [1:0]          brightness,
    output logic [1:0]          state
);

    localparam int CNT_W = $clog2(SCENE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCENE_FRAMES - 1);

    logic                edge_pulse;
    logic                frame_tick_q;
    anim_state_t         state_q;
    logic [SCROLL_W-1:0] fg_q;
    logic [SCROLL_W-1:0] bg_q;
    logic [SCENE_W-1:0]  scene_q;
    logic [1:0]          bright_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SCROLL_W-1:0] step;

    vsync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_vsync_edge (
        .clk     (clk),
        .rst     (rst),
        .async_i (v_sync),
        .pulse_o (edge_pulse)
    );

    // step = speed + 1; speed is only consumed on the tick edge.
    assign step = {{(SCROLL_W-2){1'b0}}, speed} + SCROLL_W'(1);

    // Retime the edge pulse so frame_tick lands SYNC_STAGES+2 edges after v_sync rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_tick_q <= 1'b0;
        else     frame_tick_q <= edge_pulse;
    end

    // Animation FSM; every register advances only on the frame_tick edge.
    // A tick is judged by the state it arrives in: the tick entering or leaving
    // HOLD does not scroll.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            fg_q     <= '0;
            bg_q     <= '0;
            scene_q  <= '0;
            bright_q <= BRIGHT_MAX;
            cnt_q    <= '0;
        end else if (frame_tick_q) begin
            case (state_q)
                ST_RUN: begin
                    if (pause_req) begin
                        state_q <= ST_HOLD;
                    end else begin
                        fg_q <= fg_q + step;
                        bg_q <= bg_q + (step << 1);
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
`ifdef ANIM_FADE_EN
                            state_q <= ST_FADE_OUT;
`else
                            scene_q <= scene_q + SCENE_W'(1);
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!pause_req) state_q <= ST_RUN;
                end
`ifdef ANIM_FADE_EN
                ST_FADE_OUT: begin
                    fg_q <= fg_q + step;
                    bg_q <= bg_q + (step << 1);
                    if (bright_q == 2'd0) begin
                        scene_q <= scene_q + SCENE_W'(1);
                        state_q <= ST_FADE_IN;
                    end else begin
                        bright_q <= bright_q - 2'd1;
                    end
                end
                ST_FADE_IN: begin
                    fg_q     <= fg_q + step;
                    bg_q     <= bg_q + (step << 1);
                    bright_q <= bright_q + 2'd1;
                    if (bright_q == BRIGHT_MAX - 2'd1) state_q <= ST_RUN;
                end
`endif
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign frame_tick = frame_tick_q;
    assign scroll_fg  = fg_q;
    assign scroll_bg  = bg_q;
    assign scene_idx  = scene_q;
    assign brightness = bright_q;
    assign state      = state_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: each v_sync pulse pushes the expected
// post-tick outputs from an arithmetic model; a monitor pops on every frame_tick.
module tb_anim_sequencer;

    localparam int SYNC  = 2;
    localparam int SF    = 4;
`ifdef ANIM_FADE_EN
    localparam bit FADE_EN = 1'b1;
`else
    localparam bit FADE_EN = 1'b0;
`endif

    typedef struct {
        int st;
        int fg;
        int bg;
        int scene;
        int b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v_sync = 1'b0;
    logic       pause_req = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       frame_tick;
    logic [9:0] scroll_fg;
    logic [9:0] scroll_bg;
    logic [2:0] scene_idx;
    logic [1:0] brightness;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    // model state: 0 RUN, 1 HOLD, 2 FADE_OUT, 3 FADE_IN
    int m_state, m_fg, m_bg, m_scene, m_b, m_cnt;

    anim_sequencer #(.SYNC_STAGES(SYNC), .SCENE_FRAMES(SF)) dut (
        .clk        (clk),
        .rst        (rst),
        .v_sync     (v_sync),
        .pause_req  (pause_req),
        .speed      (speed),
        .frame_tick (frame_tick),
        .scroll_fg  (scroll_fg),
        .scroll_bg  (scroll_bg),
        .scene_idx  (scene_idx),
        .brightness (brightness),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_fg = 0; m_bg = 0; m_scene = 0; m_b = 3; m_cnt = 0;
    endtask

    task automatic model_scroll(input int step);
        m_fg = (m_fg + step) % 1024;
        m_bg = (m_bg + 2 * step) % 1024;
    endtask

    task automatic model_tick(input bit p, input int s);
        int step;
        step = s + 1;
        case (m_state)
            0: begin
                if (p) m_state = 1;
                else begin
                    model_scroll(step);
                    if (m_cnt == SF - 1) begin
                        m_cnt = 0;
                        if (FADE_EN) m_state = 2;
                        else         m_scene = (m_scene + 1) % 8;
                    end else m_cnt = m_cnt + 1;
                end
            end
            1: if (!p) m_state = 0;
            2: begin
                model_scroll(step);
                if (m_b == 0) begin m_scene = (m_scene + 1) % 8; m_state = 3; end
                else m_b = m_b - 1;
            end
            default: begin
                model_scroll(step);
                m_b = m_b + 1;
                if (m_b == 3) m_state = 0;
            end
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.st = m_state; e.fg = m_fg; e.bg = m_bg; e.scene = m_scene; e.b = m_b;
        exp_q.push_back(e);
    endtask

    // One v_sync pulse with pause/speed held across the tick; also checks latency.
    task automatic pulse(input bit p, input int s);
        int lat;
        pause_req = p;
        speed = 2'(s);
        model_tick(p, s);
        push_exp();
        @(posedge clk); #1 v_sync = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (frame_tick === 1'b1 && lat == 0) lat = i;
        end
        tests++;
        if (lat != SYNC + 2) begin
            fails++;
            $display("FAIL tick_latency: got %0d edges, want %0d", lat, SYNC + 2);
        end
        v_sync = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d expected ticks never seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_now(input string name, input int st, input int fg, input int bg,
                             input int sc, input int b);
        tests++;
        if (int'(state) != st || int'(scroll_fg) != fg || int'(scroll_bg) != bg ||
            int'(scene_idx) != sc || int'(brightness) != b || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL %s: got st=%0d fg=%0d bg=%0d sc=%0d b=%0d tick=%b, want st=%0d fg=%0d bg=%0d sc=%0d b=%0d tick=0",
                     name, state, scroll_fg, scroll_bg, scene_idx, brightness, frame_tick,
                     st, fg, bg, sc, b);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Monitor: on each frame_tick, compare the outputs after the update edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                @(negedge clk);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_tick: st=%0d fg=%0d", state, scroll_fg);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(state) != e.st || int'(scroll_fg) != e.fg || int'(scroll_bg) != e.bg ||
                        int'(scene_idx) != e.scene || int'(brightness) != e.b || frame_tick !== 1'b0) begin
                        fails++;
                        $display("FAIL tick_outputs: got st=%0d fg=%0d bg=%0d sc=%0d b=%0d tick=%b, want st=%0d fg=%0d bg=%0d sc=%0d b=%0d tick=0",
                                 state, scroll_fg, scroll_bg, scene_idx, brightness, frame_tick,
                                 e.st, e.fg, e.bg, e.scene, e.b);
                    end else begin
                        $display("[TB] tick ok st=%0d fg=%0d bg=%0d sc=%0d b=%0d",
                                 state, scroll_fg, scroll_bg, scene_idx, brightness);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_now("reset_state", 0, 0, 0, 0, 3);

        // five ticks at speed 0
        for (int i = 0; i < 5; i++) pulse(1'b0, 0);
        drain();
        check_now("five_ticks", m_state, 5, 10, m_scene, m_b);

        // 255 ticks at speed 3 then one more to wrap both layers
        do_reset();
        for (int i = 0; i < 255; i++) pulse(1'b0, 3);
        drain();
        check_now("preload_1020", m_state, 1020, 1016, m_scene, m_b);
        pulse(1'b0, 3);
        drain();
        check_now("scroll_wrap", m_state, 0, 0, m_scene, m_b);

        // pause: 9 running ticks, 4 held ticks, then release
        do_reset();
        for (int i = 0; i < 9; i++) pulse(1'b0, 1);
        for (int i = 0; i < 4; i++) pulse(1'b1, 1);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1);
        drain();

        // 32 ticks: scene index wraps after 8 scenes (no-fade build)
        do_reset();
        for (int i = 0; i < 32; i++) pulse(1'b0, 0);
        drain();
        check_now("scene_sweep", m_state, m_fg, m_bg, m_scene, m_b);

        // randomized pause/speed mix, including pause during fades
        do_reset();
        for (int i = 0; i < 150; i++) pulse(($urandom_range(3) == 0), int'($urandom_range(3)));
        drain();

        // asynchronous reset mid-scene (mid-fade with brightness 1 when fading)
        do_reset();
        n = 0;
        while (n < 20 && !(FADE_EN ? (m_state == 2 && m_b == 1) : (n >= 6))) begin
            pulse(1'b0, 2);
            n++;
        end
        drain();
        @(posedge clk); #3 rst = 1'b1;
        #1 check_now("async_reset", 0, 0, 0, 0, 3);
        repeat (2) @(posedge clk);
        model_reset();

        // reset released while v_sync is high yields exactly one tick
        v_sync = 1'b1;
        pause_req = 1'b0;
        speed = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_tick(1'b0, 0);
        push_exp();
        repeat (12) @(posedge clk);
        #1 v_sync = 1'b0;
        drain();
        check_now("reset_vsync_high", m_state, 1, 2, m_scene, m_b);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
